// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory initiator: size codes, FSM states and the
// alignment rule applied before any access reaches the RAM.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StResp,
    StErr
  } state_e;

  // True when the size code is legal and the low address bits suit it.
  function automatic logic access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Sign- or zero-extends right-justified load data according to the access size.
module load_extender
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_ext_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{16{sign_ext_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the big-endian data RAM. Every output is
// registered; legal accesses take SETUP, STROBE and RESP cycles, illegal ones go to ERR.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_size,
  output logic [31:0]       mem_datain,
  input  logic [31:0]       mem_dataout
);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic [31:0]         mem_datain_q, mem_datain_d;
  logic                sign_ext_q, sign_ext_d;
  logic [31:0]         ext_data;

  load_extender u_load_extender (
    .size_i     (mem_size_q),
    .sign_ext_i (sign_ext_q),
    .data_i     (mem_dataout),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_error_d   = 1'b0;
    mem_enable_d  = 1'b0;
    mem_rw_d      = mem_rw_q;
    mem_address_d = mem_address_q;
    mem_size_d    = mem_size_q;
    mem_datain_d  = mem_datain_q;
    sign_ext_d    = sign_ext_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (access_ok(req_size, req_addr[1:0])) begin
            state_d       = StSetup;
            mem_rw_d      = req_write;
            mem_address_d = req_addr;
            mem_size_d    = req_size;
            mem_datain_d  = req_wdata;
            sign_ext_d    = req_signed;
          end else begin
            // Rejected: memory fields keep their old values, only the direction is parked.
            state_d     = StErr;
            mem_rw_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d      = StStrobe;
        mem_enable_d = 1'b1;
      end
      StStrobe: begin
        // RAM read data is valid while Enable is high; capture it on the closing edge.
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_rw_q ? 32'h0 : ext_data;
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_address_q <= '0;
      mem_size_q    <= '0;
      mem_datain_q  <= '0;
      sign_ext_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      mem_enable_q  <= mem_enable_d;
      mem_rw_q      <= mem_rw_d;
      mem_address_q <= mem_address_d;
      mem_size_q    <= mem_size_d;
      mem_datain_q  <= mem_datain_d;
      sign_ext_q    <= sign_ext_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign mem_enable  = mem_enable_q;
  assign mem_rw      = mem_rw_q;
  assign mem_address = mem_address_q;
  assign mem_size    = mem_size_q;
  assign mem_datain  = mem_datain_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural big-endian byte RAM attached.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_enable;
  logic        mem_rw;
  logic [6:0]  mem_address;
  logic [1:0]  mem_size;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ram [128];
  logic [7:0] snap [128];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .mem_enable  (mem_enable),
    .mem_rw      (mem_rw),
    .mem_address (mem_address),
    .mem_size    (mem_size),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout)
  );

  // RAM: commits writes on the rising edge of Enable, reads combinationally while enabled.
  always @(posedge mem_enable) begin
    if (mem_rw) begin
      case (mem_size)
        2'b00: ram[mem_address] = mem_datain[7:0];
        2'b01: begin
          ram[mem_address]      = mem_datain[15:8];
          ram[mem_address + 7'd1] = mem_datain[7:0];
        end
        default: begin
          ram[mem_address]        = mem_datain[31:24];
          ram[mem_address + 7'd1] = mem_datain[23:16];
          ram[mem_address + 7'd2] = mem_datain[15:8];
          ram[mem_address + 7'd3] = mem_datain[7:0];
        end
      endcase
    end
  end

  always_comb begin
    mem_dataout = 32'h0;
    if (mem_enable && !mem_rw) begin
      case (mem_size)
        2'b00:   mem_dataout = {24'h0, ram[mem_address]};
        2'b01:   mem_dataout = {16'h0, ram[mem_address], ram[mem_address + 7'd1]};
        default: mem_dataout = {ram[mem_address], ram[mem_address + 7'd1],
                                ram[mem_address + 7'd2], ram[mem_address + 7'd3]};
      endcase
    end
  end

  function automatic logic [31:0] ram_word(input logic [6:0] a);
    return {ram[a], ram[a + 7'd1], ram[a + 7'd2], ram[a + 7'd3]};
  endfunction

  // One request; lat is the cycle of rsp_valid counted from the accept edge (-1 on timeout).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [6:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int en_cycles, output logic rdy_after);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_before_req: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 'x; er = 'x; en_cycles = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_enable) en_cycles++;
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; er = rsp_error;
        break;
      end
    end
    @(negedge clk);
    rdy_after = req_ready;
  endtask

  task automatic check_rsp(input string name, input int lat, input logic [31:0] rd,
                           input logic er, input int en, input logic rdy,
                           input int exp_lat, input logic [31:0] exp_rd,
                           input logic exp_er, input int exp_en);
    vectors++;
    if (lat !== exp_lat || rd !== exp_rd || er !== exp_er || en !== exp_en || rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: got lat=%0d rdata=%h err=%b en=%0d rdy=%b want lat=%0d rdata=%h err=%b en=%0d rdy=1",
               name, lat, rd, er, en, rdy, exp_lat, exp_rd, exp_er, exp_en);
    end
  endtask

  int          lat, en;
  logic [31:0] rd;
  logic        er, rdy;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
               req_ready, rsp_valid, rsp_error, rsp_rdata);
    end
    vectors++;
    if (mem_enable !== 1'b0 || mem_rw !== 1'b0 || mem_address !== 7'h0 ||
        mem_size !== 2'b00 || mem_datain !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem: got en=%b rw=%b addr=%h size=%b din=%h want all 0",
               mem_enable, mem_rw, mem_address, mem_size, mem_datain);
    end
  endtask

  task automatic test_word();
    do_req(1'b1, 2'b10, 1'b0, 7'h10, 32'hDEADBEEF, lat, rd, er, en, rdy);
    check_rsp("store_word", lat, rd, er, en, rdy, 3, 32'h0, 1'b0, 1);
    vectors++;
    if (ram_word(7'h10) !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL ram_word_10: got %h want deadbeef", ram_word(7'h10));
    end
    do_req(1'b0, 2'b10, 1'b1, 7'h10, 32'h0, lat, rd, er, en, rdy);
    check_rsp("load_word", lat, rd, er, en, rdy, 3, 32'hDEADBEEF, 1'b0, 1);
  endtask

  task automatic test_byte();
    do_req(1'b1, 2'b00, 1'b0, 7'h21, 32'h12345680, lat, rd, er, en, rdy);
    check_rsp("store_byte", lat, rd, er, en, rdy, 3, 32'h0, 1'b0, 1);
    vectors++;
    if (ram[7'h21] !== 8'h80 || ram[7'h20] !== 8'h00 || ram[7'h22] !== 8'h00) begin
      miscompares++;
      $display("FAIL ram_byte_21: got %h %h %h want 00 80 00", ram[7'h20], ram[7'h21], ram[7'h22]);
    end
    do_req(1'b0, 2'b00, 1'b1, 7'h21, 32'h0, lat, rd, er, en, rdy);
    check_rsp("load_sbyte", lat, rd, er, en, rdy, 3, 32'hFFFFFF80, 1'b0, 1);
    do_req(1'b0, 2'b00, 1'b0, 7'h21, 32'h0, lat, rd, er, en, rdy);
    check_rsp("load_ubyte", lat, rd, er, en, rdy, 3, 32'h00000080, 1'b0, 1);
  endtask

  task automatic test_half();
    do_req(1'b1, 2'b10, 1'b0, 7'h30, 32'h0, lat, rd, er, en, rdy);
    do_req(1'b1, 2'b01, 1'b0, 7'h30, 32'hABCD8001, lat, rd, er, en, rdy);
    check_rsp("store_half", lat, rd, er, en, rdy, 3, 32'h0, 1'b0, 1);
    do_req(1'b0, 2'b01, 1'b1, 7'h30, 32'h0, lat, rd, er, en, rdy);
    check_rsp("load_shalf", lat, rd, er, en, rdy, 3, 32'hFFFF8001, 1'b0, 1);
    do_req(1'b0, 2'b01, 1'b0, 7'h30, 32'h0, lat, rd, er, en, rdy);
    check_rsp("load_uhalf", lat, rd, er, en, rdy, 3, 32'h00008001, 1'b0, 1);
    do_req(1'b0, 2'b10, 1'b1, 7'h30, 32'h0, lat, rd, er, en, rdy);
    check_rsp("load_word_30", lat, rd, er, en, rdy, 3, 32'h80010000, 1'b0, 1);
  endtask

  task automatic test_top_word();
    do_req(1'b1, 2'b10, 1'b0, 7'h7C, 32'hCAFEF00D, lat, rd, er, en, rdy);
    check_rsp("store_top", lat, rd, er, en, rdy, 3, 32'h0, 1'b0, 1);
    do_req(1'b0, 2'b10, 1'b0, 7'h7C, 32'h0, lat, rd, er, en, rdy);
    check_rsp("load_top", lat, rd, er, en, rdy, 3, 32'hCAFEF00D, 1'b0, 1);
  endtask

  task automatic test_errors();
    int diffs;
    for (int i = 0; i < 128; i++) snap[i] = ram[i];
    // Prime mem_rw=1 and mem_address=0x7C with a legal store of the same value.
    do_req(1'b1, 2'b10, 1'b0, 7'h7C, 32'hCAFEF00D, lat, rd, er, en, rdy);
    do_req(1'b1, 2'b10, 1'b0, 7'h13, 32'h55555555, lat, rd, er, en, rdy);
    check_rsp("err_store_word_13", lat, rd, er, en, rdy, 1, 32'h0, 1'b1, 0);
    vectors++;
    if (mem_rw !== 1'b0 || mem_address !== 7'h7C || mem_size !== 2'b10 ||
        mem_datain !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL err_mem_fields: got rw=%b addr=%h size=%b din=%h want 0 7c 10 cafef00d",
               mem_rw, mem_address, mem_size, mem_datain);
    end
    do_req(1'b0, 2'b10, 1'b0, 7'h13, 32'h0, lat, rd, er, en, rdy);
    check_rsp("err_load_word_13", lat, rd, er, en, rdy, 1, 32'h0, 1'b1, 0);
    do_req(1'b1, 2'b01, 1'b1, 7'h05, 32'h1234, lat, rd, er, en, rdy);
    check_rsp("err_half_05", lat, rd, er, en, rdy, 1, 32'h0, 1'b1, 0);
    do_req(1'b1, 2'b11, 1'b0, 7'h00, 32'hFFFFFFFF, lat, rd, er, en, rdy);
    check_rsp("err_size11", lat, rd, er, en, rdy, 1, 32'h0, 1'b1, 0);
    diffs = 0;
    for (int i = 0; i < 128; i++) if (ram[i] !== snap[i]) diffs++;
    vectors++;
    if (diffs !== 0) begin
      miscompares++;
      $display("FAIL err_ram_unchanged: got %0d changed bytes want 0", diffs);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 7'h40; req_wdata = 32'h01020304;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      vectors++;
      if (mem_enable !== (c % 4 == 2) || req_ready !== (c % 4 == 0) ||
          rsp_valid !== (c % 4 == 3) || rsp_error !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got en=%b rdy=%b vld=%b err=%b want en=%b rdy=%b vld=%b err=0",
                 c, mem_enable, req_ready, rsp_valid, rsp_error,
                 (c % 4 == 2), (c % 4 == 0), (c % 4 == 3));
      end
      if (c == 4) begin req_addr = 7'h44; req_wdata = 32'hA5A5A5A5; end
      if (c == 8) begin req_addr = 7'h48; req_wdata = 32'h0BADF00D; end
      if (c == 12) req_valid = 1'b0;
    end
    vectors++;
    if (ram_word(7'h40) !== 32'h01020304 || ram_word(7'h44) !== 32'hA5A5A5A5 ||
        ram_word(7'h48) !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL b2b_ram: got %h %h %h want 01020304 a5a5a5a5 0badf00d",
               ram_word(7'h40), ram_word(7'h44), ram_word(7'h48));
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_req(1'b1, 2'b10, 1'b0, 7'h50, 32'h11223344, lat, rd, er, en, rdy);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 7'h50;
    req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || mem_enable !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_after_reset: got rdy=%b en=%b vld=%b want 1 0 0",
               req_ready, mem_enable, rsp_valid);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_enable !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad);
    end
    vectors++;
    if (ram_word(7'h50) !== 32'h11223344) begin
      miscompares++;
      $display("FAIL rstmid_ram: got %h want 11223344", ram_word(7'h50));
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 8'h00;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_top_word();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
